// File: rtl/qq_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : qq_req_arbiter_if
// Description : Client request/response bus and quick-queue node port of the
//               round-robin request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface qq_req_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 32
);
    logic [N_REQ-1:0]   req_valid_i;
    logic [N_REQ-1:0]   req_op_i;
    logic [N_REQ*W-1:0] req_data_i;
    logic [N_REQ-1:0]   req_ready_o;
    logic [N_REQ-1:0]   rsp_valid_o;
    logic [W-1:0]       rsp_data_o;
    logic               rsp_err_o;
    logic [7:0]         depth_i;
    logic               q_enq_o;
    logic               q_deq_o;
    logic [W-1:0]       q_data_o;
    logic               q_done_i;
    logic [W-1:0]       q_data_i;
    logic [7:0]         count_o;
    logic               fault_o;

    // Arbiter side.
    modport master (
        input  req_valid_i, req_op_i, req_data_i, depth_i, q_done_i, q_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               q_enq_o, q_deq_o, q_data_o, count_o, fault_o
    );

    // Client / node side.
    modport slave (
        output req_valid_i, req_op_i, req_data_i, depth_i, q_done_i, q_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               q_enq_o, q_deq_o, q_data_o, count_o, fault_o
    );
endinterface
`default_nettype wire

// File: rtl/qq_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : qq_req_arbiter
// Description : Round-robin arbiter sequencing enqueue/dequeue requests from
//               N_REQ clients onto one quick-queue node, with occupancy tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module qq_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic         clk,
    input  wire logic         rst,
    qq_req_arbiter_if.master  bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   id_q, id_d;
    logic               op_q, op_d;
    logic [W-1:0]       data_q, data_d;
    logic [W-1:0]       rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic [7:0]         count_q, count_d;
    logic               fault_q, fault_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;

    logic               found;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   cand;
    logic [N_REQ-1:0]   grant;

    // Search starts at ptr and wraps, so the last-served client has lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (!found && bus.req_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        grant = found ? ({{(N_REQ-1){1'b0}}, 1'b1} << win) : '0;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        op_d       = op_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        count_d    = count_q;
        fault_d    = fault_q;
        wdog_d     = wdog_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    id_d   = win;
                    op_d   = bus.req_op_i[win];
                    data_d = bus.req_data_i[win*W +: W];
                    if (!bus.req_op_i[win] && (count_q == bus.depth_i)) begin
                        state_d    = RESP;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end else if (bus.req_op_i[win] && (count_q == 8'd0)) begin
                        state_d    = RESP;
                        rsp_data_d = '1;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end

            WAIT: begin
                if (bus.q_done_i) begin
                    rsp_data_d = op_q ? bus.q_data_i : data_q;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    fault_d    = 1'b1;
                    state_d    = RESP;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end

            RESP: begin
                if (!rsp_err_q) begin
                    count_d = op_q ? (count_q - 8'd1) : (count_q + 8'd1);
                end
                ptr_d   = (id_q == PTR_W'(N_REQ - 1)) ? '0 : (id_q + PTR_W'(1));
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            op_q       <= 1'b0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            count_q    <= 8'd0;
            fault_q    <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            op_q       <= op_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
            wdog_q     <= wdog_d;
        end
    end

    assign bus.req_ready_o = (state_q == IDLE) ? grant : '0;
    assign bus.rsp_valid_o = (state_q == RESP) ? ({{(N_REQ-1){1'b0}}, 1'b1} << id_q) : '0;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.q_enq_o     = (state_q == ISSUE) && !op_q;
    assign bus.q_deq_o     = (state_q == ISSUE) && op_q;
    assign bus.q_data_o    = data_q;
    assign bus.count_o     = count_q;
    assign bus.fault_o     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_qq_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_qq_req_arbiter
// Description : Directed self-checking bench for qq_req_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qq_req_arbiter;
    localparam int N_REQ   = 4;
    localparam int W       = 32;
    localparam int TIMEOUT = 255;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    qq_req_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

    qq_req_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] vmask, input logic op, input int win,
                           input logic [31:0] d);
        bus.req_valid_i = vmask;
        bus.req_op_i    = {4{op}};
        for (int i = 0; i < N_REQ; i++)
            bus.req_data_i[i*W +: W] = (i == win) ? d : ~d;
    endtask

    // Successful transaction, node answers in the first WAIT cycle.
    task automatic txn_ok(input logic [3:0] vmask, input int win, input logic op,
                          input logic [31:0] d, input logic [31:0] node_d,
                          input logic [31:0] exp_d);
        logic [3:0] oh;
        oh = 4'b0001 << win;
        set_req(vmask, op, win, d);
        #1;
        chk("grant", bus.req_ready_o, oh);
        tick();
        bus.req_valid_i = '0;
        chk("cmd_enq", bus.q_enq_o, !op);
        chk("cmd_deq", bus.q_deq_o, op);
        chk("cmd_data", bus.q_data_o, d);
        tick();
        chk("wait_rsp", bus.rsp_valid_o, 4'b0000);
        bus.q_done_i = 1'b1;
        bus.q_data_i = node_d;
        tick();
        bus.q_done_i = 1'b0;
        chk("rsp_valid", bus.rsp_valid_o, oh);
        chk("rsp_data", bus.rsp_data_o, exp_d);
        chk("rsp_err", bus.rsp_err_o, 1'b0);
        tick();
    endtask

    task automatic txn_rej(input logic [3:0] vmask, input int win, input logic op,
                           input logic [31:0] exp_d);
        logic [3:0] oh;
        oh = 4'b0001 << win;
        set_req(vmask, op, win, 32'h0BAD0BAD);
        #1;
        chk("rej_grant", bus.req_ready_o, oh);
        tick();
        bus.req_valid_i = '0;
        chk("rej_valid", bus.rsp_valid_o, oh);
        chk("rej_data", bus.rsp_data_o, exp_d);
        chk("rej_err", bus.rsp_err_o, 1'b1);
        chk("rej_nocmd", {bus.q_enq_o, bus.q_deq_o}, 2'b00);
        tick();
    endtask

    initial begin
        int exp_win[5];
        logic [3:0] oh;
        exp_win = '{0, 1, 2, 3, 0};

        rst             = 1'b1;
        bus.req_valid_i = '0;
        bus.req_op_i    = '0;
        bus.req_data_i  = '0;
        bus.depth_i     = 8'd4;
        bus.q_done_i    = 1'b0;
        bus.q_data_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_count", bus.count_o, 8'd0);
        chk("reset_fault", bus.fault_o, 1'b0);
        chk("reset_strobes", {bus.req_ready_o, bus.rsp_valid_o, bus.q_enq_o, bus.q_deq_o}, 10'd0);
        chk("reset_rsp_data", bus.rsp_data_o, 32'd0);
        chk("reset_q_data", bus.q_data_o, 32'd0);
        rst = 1'b0;
        tick();

        // Client 0 enqueue, node done two cycles after the command.
        set_req(4'b0001, 1'b0, 0, 32'h12345678);
        #1;
        chk("t1_grant", bus.req_ready_o, 4'b0001);
        tick();
        bus.req_valid_i = '0;
        chk("t1_enq", bus.q_enq_o, 1'b1);
        chk("t1_q_data", bus.q_data_o, 32'h12345678);
        tick();
        chk("t1_enq_once", bus.q_enq_o, 1'b0);
        tick();
        bus.q_done_i = 1'b1;
        bus.q_data_i = 32'h0BADF00D;
        tick();
        bus.q_done_i = 1'b0;
        chk("t1_rsp_valid", bus.rsp_valid_o, 4'b0001);
        chk("t1_rsp_data", bus.rsp_data_o, 32'h12345678);
        chk("t1_rsp_err", bus.rsp_err_o, 1'b0);
        chk("t1_count_hold", bus.count_o, 8'd0);
        tick();
        chk("t1_count", bus.count_o, 8'd1);

        // Successful dequeue from client 2 returns node data.
        txn_ok(4'b0100, 2, 1'b1, 32'h11111111, 32'hCAFEF00D, 32'hCAFEF00D);
        chk("t2_count", bus.count_o, 8'd0);

        // Dequeue at empty: reject; ptr=3 so client 1 wins after wrap.
        txn_rej(4'b0010, 1, 1'b1, 32'hFFFFFFFF);
        chk("t3_count", bus.count_o, 8'd0);

        // Capacity 2: two enqueues succeed, third is rejected.
        bus.depth_i = 8'd2;
        txn_ok(4'b0010, 1, 1'b0, 32'h000000A1, 32'h0, 32'h000000A1);
        txn_ok(4'b0010, 1, 1'b0, 32'h000000A2, 32'h0, 32'h000000A2);
        chk("t4_count_full", bus.count_o, 8'd2);
        txn_rej(4'b0010, 1, 1'b0, 32'h00000000);
        chk("t4_count_after_rej", bus.count_o, 8'd2);

        // Bring ptr back to 0, then all clients request continuously (full queue).
        txn_rej(4'b1000, 3, 1'b0, 32'h00000000);
        set_req(4'b1111, 1'b0, 0, 32'h0);
        #1;
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << exp_win[i];
            chk("rr_grant", bus.req_ready_o, oh);
            tick();
            chk("rr_no_grant_in_resp", bus.req_ready_o, 4'b0000);
            chk("rr_rsp_valid", bus.rsp_valid_o, oh);
            tick();
        end
        bus.req_valid_i = '0;

        // Watchdog: node never answers.
        bus.depth_i = 8'd4;
        set_req(4'b0100, 1'b0, 2, 32'hDEADBEEF);
        #1;
        chk("to_grant", bus.req_ready_o, 4'b0100);
        tick();
        bus.req_valid_i = '0;
        chk("to_enq", bus.q_enq_o, 1'b1);
        tick();
        repeat (TIMEOUT - 1) tick();
        chk("to_no_rsp_early", bus.rsp_valid_o, 4'b0000);
        chk("to_fault_early", bus.fault_o, 1'b0);
        tick();
        chk("to_rsp_valid", bus.rsp_valid_o, 4'b0100);
        chk("to_rsp_err", bus.rsp_err_o, 1'b1);
        chk("to_rsp_data", bus.rsp_data_o, 32'd0);
        chk("to_fault", bus.fault_o, 1'b1);
        tick();
        chk("to_count", bus.count_o, 8'd2);
        tick();
        chk("to_fault_sticky", bus.fault_o, 1'b1);

        // Asynchronous reset while waiting on the node.
        set_req(4'b1000, 1'b0, 3, 32'h00000055);
        #1;
        chk("rst_grant", bus.req_ready_o, 4'b1000);
        tick();
        bus.req_valid_i = '0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_count", bus.count_o, 8'd0);
        chk("rst_fault", bus.fault_o, 1'b0);
        chk("rst_q_data", bus.q_data_o, 32'd0);
        chk("rst_strobes", {bus.req_ready_o, bus.rsp_valid_o, bus.q_enq_o, bus.q_deq_o}, 10'd0);
        tick();
        rst = 1'b0;
        bus.q_done_i = 1'b1;
        tick();
        bus.q_done_i = 1'b0;
        chk("rst_no_rsp", bus.rsp_valid_o, 4'b0000);
        tick();
        txn_ok(4'b1001, 0, 1'b0, 32'h00000077, 32'h0, 32'h00000077);
        chk("rst_count_after", bus.count_o, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/qq_req_arbiter.md
# qq_req_arbiter

Round-robin request arbiter and transaction sequencer that shares one quick-queue node between several client requesters. It accepts enqueue and dequeue requests over a valid/ready handshake. Each granted request is issued to the node as a single-cycle command, and the arbiter waits for the node's `done`. It returns a per-client response and tracks queue occupancy, which it feeds to the node as its array-size input. Requests that would overflow or underflow the queue are rejected locally and never reach the node.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `W`, 32: data width.
- `TIMEOUT`, 255: maximum cycles spent in WAIT before a fault is declared.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid_i` in N_REQ: per-client request valid.
- `req_op_i` in N_REQ: per-client op; 0 = enqueue, 1 = dequeue.
- `req_data_i` in N_REQ*W: per-client enqueue data; client i occupies bits [i*W +: W].
- `req_ready_o` out N_REQ: grant / accept strobe, at most one bit high.
- `rsp_valid_o` out N_REQ: one-cycle response strobe to the owning client.
- `rsp_data_o` out W: response data, shared by all clients.
- `rsp_err_o` out 1: response is an error; qualified by `rsp_valid_o`.
- `depth_i` in 8: queue capacity; must be held static while the arbiter is not IDLE.
- `q_enq_o` out 1: one-cycle enqueue command to the node.
- `q_deq_o` out 1: one-cycle dequeue command to the node.
- `q_data_o` out W: data presented to the node's left-hand input.
- `q_done_i` in 1: node has completed the command.
- `q_data_i` in W: value returned by the node on dequeue.
- `count_o` out 8: current occupancy, driven to the node's array-size input.
- `fault_o` out 1: sticky watchdog fault; cleared only by `rst`.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - Winner = first i with `req_valid_i[i]`, searched from `ptr` upward, modulo N_REQ.
  - `req_ready_o[winner]` is driven combinationally in the same cycle.
  - On the clock edge, id, op and data are latched.
  - Enqueue with `count_o == depth_i`: go to RESP with reject; data = 32'h00000000, err = 1.
  - Dequeue with `count_o == 0`: go to RESP with reject; data = 32'hFFFFFFFF, err = 1.
  - Otherwise go to ISSUE.
- ISSUE
  - Exactly one of `q_enq_o` / `q_deq_o` is high for one cycle.
  - `q_data_o` = latched data; it holds until RESP.
  - Go to WAIT.
- WAIT
  - A watchdog counter counts cycles spent in WAIT.
  - On `q_done_i`: capture `q_data_i` on dequeue, or the latched data on enqueue; go to RESP with err = 0.
  - If the counter reaches TIMEOUT before done: go to RESP with err = 1 and data = 0, set `fault_o`.
- RESP
  - `rsp_valid_o[id]` is high for one cycle, with `rsp_data_o` and `rsp_err_o` valid.
  - `count_o` changes only on a successful response: +1 for enqueue, -1 for dequeue.
  - `ptr` = (id + 1) mod N_REQ.
  - Go to IDLE.
- `q_done_i` outside WAIT is ignored.
- Clients must hold valid, op and data stable until they see ready.
- A client may deassert valid before being granted.
- While `fault_o` = 1 the arbiter continues to operate; the flag is informational.

## Timing
- Reset values: state IDLE, `ptr` = 0, `count_o` = 0, `fault_o` = 0; all strobes 0, `rsp_data_o` = 0, `q_data_o` = 0.
- Reset mid-transaction aborts it: no response is produced and any command already issued to the node is discarded.
- Accept at edge T. `q_enq_o` / `q_deq_o` is high in cycle T+1.
- `q_done_i` is sampled from cycle T+2 onward. If done arrives in cycle D, the response is in cycle D+1.
- Minimum accept-to-response latency is 3 cycles.
- A reject responds in cycle T+1 and issues no node command.
- Next accept is possible in the cycle after RESP, so there are at least 2 cycles between grants on the reject path and at least 4 on the success path.
- `count_o` updates at the end of the RESP cycle and is visible in the following IDLE cycle.
- Simultaneous requests are resolved purely by `ptr`; there is no op priority.

## Test plan
- Single client 0 enqueues 0x12345678, node done 2 cycles after the command: one `q_enq_o` pulse carrying 0x12345678; `rsp_valid_o` = 0001 with err 0; `count_o` goes 0 -> 1.
- Dequeue at count 0: `rsp_valid_o` at T+1 with data 0xFFFFFFFF and err 1; no `q_deq_o`; count stays 0.
- `depth_i` = 2, three enqueues from client 1: the first two succeed; the third is rejected with data 0 and err 1; count is 2.
- All four clients hold valid continuously: grant order 0, 1, 2, 3, 0; each grant is one cycle, and `req_ready_o` is never multi-hot.
- `q_done_i` never asserted after an enqueue: response with err 1 and data 0 exactly TIMEOUT cycles into WAIT; `fault_o` = 1 and sticky; count unchanged.
- `rst` asserted during WAIT: all outputs return to reset values asynchronously; a later enqueue after reset starts from count 0 with grant to client 0.
